// File: rtl/avalon_mm_read_ob.sv
// Avalon-MM burst read master: splits a beat count into max-length bursts, throttles issue
// by response-FIFO credit, and streams returned beats to a show-ahead consumer interface.
module avalon_mm_read_ob #(
  parameter int unsigned MAXBURST_LOG   = 4,
  parameter int unsigned READNUM_SIZE   = 32,
  parameter int unsigned DRAM_ADDRSPACE = 64,
  parameter int unsigned DRAM_DATAWIDTH = 512,
  parameter int unsigned FIFO_DEPTH_LOG = 6
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          READ_REQ,
  input  logic [DRAM_ADDRSPACE-1:0]     READ_INITADDR,
  input  logic [READNUM_SIZE:0]         READ_NUM,
  output logic [DRAM_DATAWIDTH-1:0]     READ_DATA,
  output logic                          READ_DATAEN,
  input  logic                          READ_DATA_READY,
  output logic                          READ_RDY,
  output logic                          READ_DONE,
  input  logic [DRAM_DATAWIDTH-1:0]     AVALON_MM_READDATA,
  input  logic                          AVALON_MM_READDATAVALID,
  input  logic                          AVALON_MM_WAITREQUEST,
  output logic [DRAM_ADDRSPACE-1:0]     AVALON_MM_ADDRESS,
  output logic                          AVALON_MM_READ,
  output logic [MAXBURST_LOG:0]         AVALON_MM_BURSTCOUNT,
  output logic [DRAM_DATAWIDTH/8-1:0]   AVALON_MM_BYTEENABLE,
  output logic                          AVALON_MM_WRITE
);

  localparam int unsigned BC_W  = MAXBURST_LOG + 1;
  localparam int unsigned NUM_W = READNUM_SIZE + 1;
  localparam int unsigned BN_W  = NUM_W + 1 - MAXBURST_LOG;
  localparam int unsigned RES_W = FIFO_DEPTH_LOG + 1;
  localparam int unsigned SUM_W = FIFO_DEPTH_LOG + 2;
  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG;

  localparam logic [BC_W-1:0]           FULL_BC   = BC_W'(2 ** MAXBURST_LOG);
  localparam logic [SUM_W-1:0]          DEPTH_SUM = SUM_W'(DEPTH);
  localparam logic [DRAM_ADDRSPACE-1:0] ADDR_INC  =
    DRAM_ADDRSPACE'((DRAM_DATAWIDTH / 8) << MAXBURST_LOG);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                      r_state, w_state_d;
  logic [DRAM_ADDRSPACE-1:0]   r_addr, w_addr_d;
  logic [BN_W-1:0]             r_bnum, w_bnum_d;
  logic [BC_W-1:0]             r_last, w_last_d;
  logic                        r_read, w_read_d;
  logic [BC_W-1:0]             r_bcount, w_bcount_d;
  logic [RES_W-1:0]            r_reserved, w_reserved_d;
  logic                        r_done, w_done_d;

  logic [DRAM_DATAWIDTH-1:0]   r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0]   r_wptr, r_rptr;
  logic [RES_W-1:0]            r_count;

  logic [NUM_W:0]              w_num_round;
  logic [BN_W-1:0]             w_bnum_init;
  logic [BC_W-1:0]             w_last_init;
  logic                        w_accept;
  logic                        w_dataen;
  logic                        w_pop;
  logic [BN_W-1:0]             w_bnum_next;
  logic [BC_W-1:0]             w_next_bc;
  logic [SUM_W-1:0]            w_res_acc;
  logic                        w_credit;

  assign w_num_round = {1'b0, READ_NUM} + (NUM_W + 1)'(2 ** MAXBURST_LOG - 1);
  assign w_bnum_init = BN_W'(w_num_round >> MAXBURST_LOG);
  assign w_last_init = (READ_NUM[MAXBURST_LOG-1:0] == '0) ? FULL_BC
                                                          : {1'b0, READ_NUM[MAXBURST_LOG-1:0]};

  assign w_accept    = r_read & ~AVALON_MM_WAITREQUEST;
  assign w_dataen    = (r_count != '0);
  assign w_pop       = w_dataen & READ_DATA_READY;
  assign w_bnum_next = w_accept ? (r_bnum - BN_W'(1)) : r_bnum;
  assign w_next_bc   = (w_bnum_next == BN_W'(1)) ? r_last : FULL_BC;

  // Credit includes the burst being accepted this edge but not a same-edge pop.
  assign w_res_acc = SUM_W'(r_reserved) + (w_accept ? SUM_W'(r_bcount) : '0);
  assign w_credit  = (w_res_acc + SUM_W'(w_next_bc)) <= DEPTH_SUM;

  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_bnum_d     = r_bnum;
    w_last_d     = r_last;
    w_read_d     = r_read;
    w_bcount_d   = r_bcount;
    w_done_d     = 1'b0;
    w_reserved_d = RES_W'(w_res_acc - SUM_W'(w_pop));

    case (r_state)
      StIdle: begin
        if (READ_REQ) begin
          if (READ_NUM == '0) begin
            w_done_d = 1'b1;
          end else begin
            w_addr_d  = READ_INITADDR;
            w_bnum_d  = w_bnum_init;
            w_last_d  = w_last_init;
            w_state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (w_accept) begin
          w_addr_d = r_addr + ADDR_INC;
          w_bnum_d = w_bnum_next;
        end
        if (w_accept && (r_bnum == BN_W'(1))) begin
          w_read_d  = 1'b0;
          w_state_d = StDrain;
        end else if (w_accept || !r_read) begin
          w_read_d   = w_credit;
          w_bcount_d = w_next_bc;
        end
      end
      StDrain: begin
        if (r_reserved == '0) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_bnum     <= '0;
      r_last     <= '0;
      r_read     <= 1'b0;
      r_bcount   <= '0;
      r_reserved <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_bnum     <= w_bnum_d;
      r_last     <= w_last_d;
      r_read     <= w_read_d;
      r_bcount   <= w_bcount_d;
      r_reserved <= w_reserved_d;
      r_done     <= w_done_d;
    end
  end

  // Response FIFO: storage is not reset, only the pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (AVALON_MM_READDATAVALID) begin
      r_mem[r_wptr] <= AVALON_MM_READDATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (AVALON_MM_READDATAVALID) begin
        r_wptr <= r_wptr + FIFO_DEPTH_LOG'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_DEPTH_LOG'(1);
      end
      r_count <= r_count + RES_W'(AVALON_MM_READDATAVALID) - RES_W'(w_pop);
    end
  end

  assign READ_DATA            = r_mem[r_rptr];
  assign READ_DATAEN          = w_dataen;
  assign READ_RDY             = (r_state == StIdle);
  assign READ_DONE            = r_done;
  assign AVALON_MM_ADDRESS    = r_addr;
  assign AVALON_MM_READ       = r_read;
  assign AVALON_MM_BURSTCOUNT = r_bcount;
  assign AVALON_MM_BYTEENABLE = '1;
  assign AVALON_MM_WRITE      = 1'b0;

endmodule

// File: tb/tb_avalon_mm_read_ob.sv
// Randomized bench for avalon_mm_read_ob: an Avalon slave/consumer model plus a
// transaction-level reference (expected bursts and beat stream) built from address arithmetic.
module tb_avalon_mm_read_ob;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int NW = 33;
  localparam int BCW = 5;
  localparam int BURST = 16;
  localparam int DEPTH = 64;
  localparam int BEAT_BYTES = 64;

  logic            CLK;
  logic            RST_N;
  logic            READ_REQ;
  logic [AW-1:0]   READ_INITADDR;
  logic [NW-1:0]   READ_NUM;
  logic [DW-1:0]   READ_DATA;
  logic            READ_DATAEN;
  logic            READ_DATA_READY;
  logic            READ_RDY;
  logic            READ_DONE;
  logic [DW-1:0]   AVALON_MM_READDATA;
  logic            AVALON_MM_READDATAVALID;
  logic            AVALON_MM_WAITREQUEST;
  logic [AW-1:0]   AVALON_MM_ADDRESS;
  logic            AVALON_MM_READ;
  logic [BCW-1:0]  AVALON_MM_BURSTCOUNT;
  logic [DW/8-1:0] AVALON_MM_BYTEENABLE;
  logic            AVALON_MM_WRITE;

  avalon_mm_read_ob dut (
    .CLK                     (CLK),
    .RST_N                   (RST_N),
    .READ_REQ                (READ_REQ),
    .READ_INITADDR           (READ_INITADDR),
    .READ_NUM                (READ_NUM),
    .READ_DATA               (READ_DATA),
    .READ_DATAEN             (READ_DATAEN),
    .READ_DATA_READY         (READ_DATA_READY),
    .READ_RDY                (READ_RDY),
    .READ_DONE               (READ_DONE),
    .AVALON_MM_READDATA      (AVALON_MM_READDATA),
    .AVALON_MM_READDATAVALID (AVALON_MM_READDATAVALID),
    .AVALON_MM_WAITREQUEST   (AVALON_MM_WAITREQUEST),
    .AVALON_MM_ADDRESS       (AVALON_MM_ADDRESS),
    .AVALON_MM_READ          (AVALON_MM_READ),
    .AVALON_MM_BURSTCOUNT    (AVALON_MM_BURSTCOUNT),
    .AVALON_MM_BYTEENABLE    (AVALON_MM_BYTEENABLE),
    .AVALON_MM_WRITE         (AVALON_MM_WRITE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_of(input logic [AW-1:0] a);
    return {8{a ^ 64'h5a5a_0f0f_3c3c_9696}};
  endfunction

  // Reference model state
  logic [AW-1:0] exp_baddr_q[$];
  int            exp_bcnt_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] slave_q[$];
  int ready_pct = 100, wait_pct = 0, valid_pct = 100;
  int hold_idx = -1, hold_left = 0, held = 0;
  int n_bursts = 0, n_done = 0, n_extra = 0;
  int tb_res = 0, tb_fifo = 0;
  logic [AW-1:0] second_addr = '0;

  // Avalon slave and consumer, acting on the falling edge
  initial begin : bus
    logic          prev_wait;
    logic [AW-1:0] prev_addr;
    logic [BCW-1:0] prev_bc;
    logic          pop;
    prev_wait = 1'b0;
    prev_addr = '0;
    prev_bc = '0;
    READ_DATA_READY = 1'b0;
    AVALON_MM_READDATA = '0;
    AVALON_MM_READDATAVALID = 1'b0;
    AVALON_MM_WAITREQUEST = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        slave_q.delete();
        tb_res = 0;
        tb_fifo = 0;
        prev_wait = 1'b0;
        AVALON_MM_READDATAVALID = 1'b0;
        AVALON_MM_WAITREQUEST = 1'b0;
        continue;
      end
      if (READ_DONE) n_done++;
      check_eq("dataen", DW'(READ_DATAEN), DW'(tb_fifo != 0));
      READ_DATA_READY = ($urandom_range(99) < ready_pct);
      pop = READ_DATAEN && READ_DATA_READY;
      if (pop) begin
        if (exp_data_q.size() == 0) n_extra++;
        else check_eq("beat_data", READ_DATA, exp_data_q.pop_front());
      end
      AVALON_MM_READDATAVALID = 1'b0;
      if (slave_q.size() != 0 && $urandom_range(99) < valid_pct) begin
        AVALON_MM_READDATA = beat_of(slave_q.pop_front());
        AVALON_MM_READDATAVALID = 1'b1;
      end
      if (hold_left > 0 && AVALON_MM_READ && n_bursts == hold_idx) begin
        AVALON_MM_WAITREQUEST = 1'b1;
        hold_left--;
        held++;
      end else begin
        AVALON_MM_WAITREQUEST = ($urandom_range(99) < wait_pct);
      end
      if (prev_wait) begin
        check_eq("hold_read", DW'(AVALON_MM_READ), DW'(1));
        check_eq("hold_addr", DW'(AVALON_MM_ADDRESS), DW'(prev_addr));
        check_eq("hold_count", DW'(AVALON_MM_BURSTCOUNT), DW'(prev_bc));
      end
      prev_wait = AVALON_MM_READ && AVALON_MM_WAITREQUEST;
      prev_addr = AVALON_MM_ADDRESS;
      prev_bc = AVALON_MM_BURSTCOUNT;
      if (AVALON_MM_READ && !AVALON_MM_WAITREQUEST) begin
        n_bursts++;
        if (n_bursts == 2) second_addr = AVALON_MM_ADDRESS;
        if (exp_baddr_q.size() == 0) begin
          n_extra++;
        end else begin
          check_eq("burst_addr", DW'(AVALON_MM_ADDRESS), DW'(exp_baddr_q.pop_front()));
          check_eq("burst_count", DW'(AVALON_MM_BURSTCOUNT), DW'(exp_bcnt_q.pop_front()));
        end
        check_eq("credit", DW'(tb_res + int'(AVALON_MM_BURSTCOUNT) <= DEPTH), DW'(1));
        tb_res += int'(AVALON_MM_BURSTCOUNT);
        for (int j = 0; j < int'(AVALON_MM_BURSTCOUNT); j++) begin
          slave_q.push_back(AVALON_MM_ADDRESS + AW'(j * BEAT_BYTES));
        end
      end
      if (pop) begin
        tb_res--;
        tb_fifo--;
      end
      if (AVALON_MM_READDATAVALID) tb_fifo++;
    end
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_model();
    exp_baddr_q.delete();
    exp_bcnt_q.delete();
    exp_data_q.delete();
  endtask

  task automatic launch(input logic [AW-1:0] a, input int n);
    n_bursts = 0;
    n_done = 0;
    n_extra = 0;
    for (int k = 0; k * BURST < n; k++) begin
      exp_baddr_q.push_back(a + AW'(k * BURST * BEAT_BYTES));
      exp_bcnt_q.push_back((n - k * BURST) > BURST ? BURST : (n - k * BURST));
    end
    for (int i = 0; i < n; i++) exp_data_q.push_back(beat_of(a + AW'(i * BEAT_BYTES)));
    READ_INITADDR = a;
    READ_NUM = NW'(n);
    READ_REQ = 1'b1;
    cyc();
    READ_REQ = 1'b0;
    check_eq("rdy_busy", DW'(READ_RDY), DW'(0));
    // A request while busy must be ignored
    READ_INITADDR = ~a;
    READ_NUM = NW'(3);
    READ_REQ = 1'b1;
    cyc();
    READ_REQ = 1'b0;
  endtask

  task automatic finish_txn(input int budget);
    int t;
    t = 0;
    while (n_done == 0 && t < budget) begin
      cyc();
      t++;
    end
    check_eq("done_seen", DW'(n_done != 0), DW'(1));
    if (n_done == 0) begin
      RST_N = 1'b0;
      clear_model();
      repeat (2) cyc();
      RST_N = 1'b1;
      cyc();
    end else begin
      repeat (3) cyc();
      check_eq("done_once", DW'(n_done), DW'(1));
      check_eq("rdy_idle", DW'(READ_RDY), DW'(1));
      check_eq("bursts_left", DW'(exp_baddr_q.size()), DW'(0));
      check_eq("beats_left", DW'(exp_data_q.size()), DW'(0));
      check_eq("extra", DW'(n_extra), DW'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rdy"}, DW'(READ_RDY), DW'(1));
    check_eq({tag, "_read"}, DW'(AVALON_MM_READ), DW'(0));
    check_eq({tag, "_dataen"}, DW'(READ_DATAEN), DW'(0));
    check_eq({tag, "_done"}, DW'(READ_DONE), DW'(0));
    check_eq({tag, "_addr"}, DW'(AVALON_MM_ADDRESS), DW'(0));
    check_eq({tag, "_bc"}, DW'(AVALON_MM_BURSTCOUNT), DW'(0));
  endtask

  initial begin : main
    logic [AW-1:0] ra;
    RST_N = 1'b0;
    READ_REQ = 1'b0;
    READ_INITADDR = '0;
    READ_NUM = '0;
    repeat (3) cyc();
    check_reset_outputs("rst");
    check_eq("byteenable", DW'(AVALON_MM_BYTEENABLE), DW'({(DW/8){1'b1}}));
    check_eq("write", DW'(AVALON_MM_WRITE), DW'(0));
    RST_N = 1'b1;
    cyc();

    // 37 beats, free-running consumer
    launch(64'h1000, 37);
    finish_txn(3000);
    check_eq("b2_addr", DW'(second_addr), DW'(64'h1400));

    // Credit throttling with a stalled consumer
    ready_pct = 0;
    launch(64'h4_0000, 128);
    repeat (150) cyc();
    check_eq("stall_bursts", DW'(n_bursts), DW'(4));
    check_eq("stall_read", DW'(AVALON_MM_READ), DW'(0));
    ready_pct = 100;
    finish_txn(3000);
    check_eq("resume_bursts", DW'(n_bursts), DW'(8));

    // Waitrequest held for 5 cycles on the second burst
    held = 0;
    hold_idx = 1;
    hold_left = 5;
    launch(64'h8000, 48);
    finish_txn(3000);
    check_eq("held_cycles", DW'(held), DW'(5));
    hold_idx = -1;

    // Zero-length request
    n_bursts = 0;
    n_done = 0;
    READ_INITADDR = 64'h9000;
    READ_NUM = '0;
    READ_REQ = 1'b1;
    cyc();
    READ_REQ = 1'b0;
    check_eq("zero_done", DW'(READ_DONE), DW'(1));
    check_eq("zero_rdy", DW'(READ_RDY), DW'(1));
    cyc();
    check_eq("zero_done_end", DW'(READ_DONE), DW'(0));
    check_eq("zero_rdy2", DW'(READ_RDY), DW'(1));
    repeat (5) cyc();
    check_eq("zero_bursts", DW'(n_bursts), DW'(0));
    check_eq("zero_done_cnt", DW'(n_done), DW'(1));

    // Address wrap
    launch(64'hFFFF_FFFF_FFFF_FC00, 32);
    finish_txn(3000);
    check_eq("wrap_addr", DW'(second_addr), DW'(0));

    // Randomized transactions
    for (int t = 0; t < 6; t++) begin
      ready_pct = $urandom_range(100, 30);
      wait_pct = $urandom_range(50, 0);
      valid_pct = $urandom_range(100, 30);
      ra = {$urandom, $urandom};
      launch(ra, $urandom_range(150, 1));
      finish_txn(8000);
    end
    ready_pct = 100;
    wait_pct = 0;
    valid_pct = 100;

    // Reset during DRAIN, then a normal transfer
    ready_pct = 0;
    launch(64'h2000, 16);
    repeat (40) cyc();
    check_eq("drain_read", DW'(AVALON_MM_READ), DW'(0));
    check_eq("drain_dataen", DW'(READ_DATAEN), DW'(1));
    check_eq("drain_busy", DW'(READ_RDY), DW'(0));
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clear_model();
    repeat (2) cyc();
    RST_N = 1'b1;
    cyc();
    ready_pct = 100;
    launch(64'h3000, 16);
    finish_txn(3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_mm_read_ob.md
AVALON_MM_READ_OB -- requirements
Module: avalon_mm_read_ob

Interface
REQ-001 SHALL have parameter MAXBURST_LOG, default 4: log2 of the maximum burst length in beats.
REQ-002 SHALL have parameter READNUM_SIZE, default 32: READ_NUM is READNUM_SIZE+1 bits.
REQ-003 SHALL have parameter DRAM_ADDRSPACE, default 64: byte-address width.
REQ-004 SHALL have parameter DRAM_DATAWIDTH, default 512: beat width in bits.
REQ-005 SHALL have parameter FIFO_DEPTH_LOG, default 6: log2 of the response FIFO depth; it must be at least MAXBURST_LOG+1.
REQ-006 SHALL have one clock and asynchronous active-low reset; ports: CLK in 1 clock; RST_N in 1 async active-low reset.
REQ-007 Ports: READ_REQ in 1 start request; READ_INITADDR in DRAM_ADDRSPACE first byte address; READ_NUM in READNUM_SIZE+1 beat count.
REQ-008 Ports: READ_DATA out DRAM_DATAWIDTH FIFO head; READ_DATAEN out 1 head valid; READ_DATA_READY in 1 consumer accept; READ_RDY out 1 idle; READ_DONE out 1 completion pulse.
REQ-009 Ports: AVALON_MM_READDATA in DRAM_DATAWIDTH; AVALON_MM_READDATAVALID in 1; AVALON_MM_WAITREQUEST in 1.
REQ-010 Ports: AVALON_MM_ADDRESS out DRAM_ADDRSPACE; AVALON_MM_READ out 1; AVALON_MM_BURSTCOUNT out MAXBURST_LOG+1; AVALON_MM_BYTEENABLE out DRAM_DATAWIDTH/8 (all ones); AVALON_MM_WRITE out 1 (tied 0).

Function
REQ-011 SHALL implement states IDLE, ISSUE, DRAIN; READ_RDY = (state==IDLE).
REQ-012 In IDLE with READ_REQ=1: latch address, burstnum = ceil(READ_NUM/2^MAXBURST_LOG), and last burst length = READ_NUM mod 2^MAXBURST_LOG, or 2^MAXBURST_LOG when the remainder is 0; go to ISSUE.
REQ-013 SHALL ignore READ_REQ outside IDLE.
REQ-014 READ_NUM=0: no Avalon traffic; READ_DONE pulses the cycle after the request; remain IDLE.
REQ-015 AVALON_MM_READ, AVALON_MM_ADDRESS and AVALON_MM_BURSTCOUNT SHALL be registered; READ rises at the earliest one edge after the accepting READ_REQ edge.
REQ-016 Burstcount SHALL be 2^MAXBURST_LOG for every burst except the last, which uses the latched last length.
REQ-017 While READ=1 and WAITREQUEST=1, address, burstcount and READ SHALL hold stable.
REQ-018 A burst is accepted when READ=1 and WAITREQUEST=0.
REQ-019 On acceptance: address += (DRAM_DATAWIDTH/8)<<MAXBURST_LOG, modulo 2^DRAM_ADDRSPACE; burstnum decrements; reserved += burstcount.
REQ-020 Credit rule: READ SHALL be asserted for the next burst only if reserved + next burstcount <= 2^FIFO_DEPTH_LOG, with reserved = beats requested but not yet popped.
REQ-021 The credit check SHALL use the registered reserved value; a same-cycle pop is not counted.
REQ-022 Back-to-back bursts are allowed: READ stays high across acceptance when credit permits.
REQ-023 After the last burst is accepted, READ SHALL deassert and the state SHALL go to DRAIN.
REQ-024 Response FIFO: push on READDATAVALID; show-ahead; READ_DATAEN = !empty; pop on READ_DATAEN & READ_DATA_READY; each pop decrements reserved.
REQ-025 Simultaneous push and pop SHALL leave the FIFO count unchanged; read/write pointers wrap modulo depth.
REQ-026 Latency from READDATAVALID to READ_DATAEN SHALL be exactly 1 cycle when the FIFO is empty.
REQ-027 FIFO overflow is impossible under REQ-020; READDATAVALID while full is a protocol violation and is not handled.
REQ-028 In DRAIN, when reserved==0 (all beats received and popped): pulse READ_DONE for 1 cycle and go to IDLE.
REQ-029 Beat order at READ_DATA SHALL equal Avalon return order; no beat is dropped or duplicated.

Reset
REQ-030 While RST_N=0: state=IDLE, AVALON_MM_READ=0, READ_RDY=1, READ_DATAEN=0, READ_DONE=0, reserved=0, FIFO empty, ADDRESS=0, BURSTCOUNT=0.
REQ-031 Reset asserted mid-transfer SHALL abort immediately; Avalon responses still in flight are not tracked (the interconnect is reset together with this block).

Verification (MAXBURST_LOG=4, FIFO_DEPTH_LOG=6, 64-byte beats)
REQ-032 READ_NUM=37, addr 0x1000, READY=1, no waitrequest -> bursts at 0x1000/0x1400/0x1800 with counts 16/16/5; 37 beats in order; one READ_DONE.
REQ-033 READ_NUM=128, READY=0 -> exactly 4 bursts (64 beats) issued, then READ stays low; raising READY resumes issue; 128 beats total.
REQ-034 WAITREQUEST high for 5 cycles on burst 2 -> address/burstcount stable throughout; exactly one acceptance.
REQ-035 READ_NUM=0 -> no AVALON_MM_READ; READ_DONE one cycle later; READ_RDY stays 1.
REQ-036 READ_INITADDR = 2^64-0x400, READ_NUM=32 -> second burst address 0x0.
REQ-037 RST_N low during DRAIN -> all outputs at reset values; after release, READ_NUM=16 completes normally.
